// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// The response record travels through the pipeline and the response FIFO as one packed word.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
   localparam int          WORD_BYTES = 4;

   typedef struct packed {
      logic        err;
      logic [31:0] addr;
      logic [31:0] instr;
   } resp_t;

   localparam int RESP_W = $bits(resp_t);

   function automatic logic word_aligned(input logic [31:0] byte_addr);
      return byte_addr[$clog2(WORD_BYTES)-1:0] == '0;
   endfunction

endpackage

// File: rtl/resp_fifo.sv
// Response FIFO with a synchronous clear (flush) and a registered, non-fall-through head.
// The head reads as all-zero whenever the FIFO is empty, so it also reads zero during reset.
module resp_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             valid
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             rd_fire;

   assign valid   = (count != '0);
   assign rd_fire = rd_en && valid;
   assign rd_data = valid ? mem[rd_ptr] : '0;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)   wr_ptr <= wr_ptr + 1'b1;
         if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; the pointers and count alone define which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en && !clr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: credit-limited fetch pipeline over a word-addressed store,
// with redirect flush and a program-load write port.
module imem_fetch_responder
   import fetch_pkg::*;
#(
   parameter int DEPTH      = 256,
   parameter int LATENCY    = 2,
   parameter int RESP_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   output logic        req_ready,
   input  logic        flush,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_instr,
   output logic [31:0] resp_addr,
   output logic        resp_err,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = $clog2(RESP_DEPTH + 1);

   logic [31:0]   store [DEPTH];
   logic [OW-1:0] outstanding;
   logic          accept;
   logic          pop;
   logic          fifo_wr;
   resp_t         rd_resp;
   resp_t         fifo_wdata;
   resp_t         head;
   logic          unused_wr_lsbs;

   assign unused_wr_lsbs = ^wr_addr[1:0];

   // Credits cover both in-flight and buffered responses, so the FIFO can never overflow.
   assign req_ready = !rst && !flush && (outstanding < OW'(RESP_DEPTH));
   assign accept    = req_valid && req_ready;
   assign pop       = resp_valid && resp_ready && !flush;

   // NOTE: every field gets a value on every path, so no latch is inferred.
   always_comb begin
      rd_resp.addr  = req_addr;
      rd_resp.err   = !word_aligned(req_addr) || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
      rd_resp.instr = rd_resp.err ? NOP_INSTR : store[req_addr[AW+1:2]];
   end

   // Read is combinational before the edge, so a same-cycle write is seen only by later fetches.
   always_ff @(posedge clk) begin
      if (wr_en && ({2'b00, wr_addr[31:2]} < 32'(DEPTH)))
         store[wr_addr[AW+1:2]] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= '0;
      end else if (flush) begin
         outstanding <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   // The accept edge counts as the first of LATENCY edges; the FIFO write is the last.
   if (LATENCY == 1) begin : g_direct
      assign fifo_wr    = accept;
      assign fifo_wdata = rd_resp;
   end else begin : g_pipe
      logic [LATENCY-2:0] pipe_valid;
      resp_t              pipe_data [LATENCY-1];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            pipe_valid <= '0;
         end else if (flush) begin
            pipe_valid <= '0;
         end else begin
            pipe_valid[0] <= accept;
            for (int i = 1; i < LATENCY - 1; i++) pipe_valid[i] <= pipe_valid[i-1];
         end
      end

      always_ff @(posedge clk) begin
         pipe_data[0] <= rd_resp;
         for (int i = 1; i < LATENCY - 1; i++) pipe_data[i] <= pipe_data[i-1];
      end

      assign fifo_wr    = pipe_valid[LATENCY-2];
      assign fifo_wdata = pipe_data[LATENCY-2];
   end

   resp_fifo #(
      .WIDTH (RESP_W),
      .DEPTH (RESP_DEPTH)
   ) u_resp_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush),
      .wr_en   (fifo_wr),
      .wr_data (fifo_wdata),
      .rd_en   (pop),
      .rd_data (head),
      .valid   (resp_valid)
   );

   assign resp_instr = head.instr;
   assign resp_addr  = head.addr;
   assign resp_err   = head.err;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: directed scenarios then random traffic, checked against a
// queue-based reference that tracks each accepted fetch and the cycle it becomes visible.
module tb_imem_fetch_responder;

   localparam int DEPTH      = 256;
   localparam int LATENCY    = 2;
   localparam int RESP_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        flush;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_instr;
   logic [31:0] resp_addr;
   logic        resp_err;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   always #5 clk = ~clk;

   imem_fetch_responder #(
      .DEPTH      (DEPTH),
      .LATENCY    (LATENCY),
      .RESP_DEPTH (RESP_DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .flush      (flush),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_instr (resp_instr),
      .resp_addr  (resp_addr),
      .resp_err   (resp_err),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        err;
      int          vis;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mdl_mem [DEPTH];
   int          cyc    = 0;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic exp_t predict(input logic [31:0] a);
      exp_t e;
      e.addr  = a;
      e.err   = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
      e.instr = e.err ? 32'h0 : mdl_mem[a[9:2]];
      e.vis   = cyc + LATENCY;
      return e;
   endfunction

   // Drives one cycle from a negedge, checks outputs, advances the model and the clock.
   task automatic cycle(input logic rv, input logic [31:0] ra, input logic rr, input logic fl,
                        input logic we, input logic [31:0] wa, input logic [31:0] wd);
      bit exp_ready;
      bit exp_valid;
      req_valid  = rv;
      req_addr   = ra;
      resp_ready = rr;
      flush      = fl;
      wr_en      = we;
      wr_addr    = wa;
      wr_data    = wd;
      #1;
      exp_ready = !fl && (q.size() < RESP_DEPTH);
      exp_valid = (q.size() > 0) && (q[0].vis <= cyc);
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("resp_valid", 32'(resp_valid), 32'(exp_valid));
      if (exp_valid) begin
         check("resp_instr", resp_instr, q[0].instr);
         check("resp_addr", resp_addr, q[0].addr);
         check("resp_err", 32'(resp_err), 32'(q[0].err));
      end
      if (fl) begin
         q.delete();
      end else begin
         if (exp_valid && rr) void'(q.pop_front());
         if (rv && exp_ready) q.push_back(predict(ra));
      end
      if (we && (wa[31:2] < 30'(DEPTH))) mdl_mem[wa[9:2]] = wd;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic rr);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, rr, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic fetch(input logic [31:0] a, input logic rr);
      cycle(1'b1, a, rr, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
      check({tag, "_resp_instr"}, resp_instr, 32'h0);
      check({tag, "_resp_addr"}, resp_addr, 32'h0);
      check({tag, "_resp_err"}, 32'(resp_err), 32'h0);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      case ($urandom_range(0, 9))
         0:       a[1:0] = 2'($urandom_range(1, 3));
         1:       a      = {20'h0, 10'($urandom_range(256, 1023)), 2'b00};
         2:       a      = 32'hFFFF_FFFC;
         default: ;
      endcase
      return a;
   endfunction

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_addr   = '0;
      resp_ready = 1'b0;
      flush      = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("por");
      @(negedge clk);
      rst = 1'b0;

      // Program load: whole store random, then the two directed words.
      for (int i = 0; i < DEPTH; i++)
         cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'(i * 4), $urandom);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h2008_0005);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h2009_000A);

      // Back-to-back fetches, then misaligned and out-of-range fetches.
      fetch(32'h0, 1'b1);
      fetch(32'h4, 1'b1);
      idle(3, 1'b1);
      fetch(32'h6, 1'b1);
      fetch(32'h400, 1'b1);
      idle(3, 1'b1);

      // Credit limit with a stalled consumer, then drain.
      for (int i = 0; i < 6; i++) fetch(32'(8 + 4 * i), 1'b0);
      idle(2, 1'b0);
      idle(6, 1'b1);

      // Flush with a request presented in the same cycle.
      fetch(32'hC, 1'b0);
      fetch(32'h10, 1'b0);
      fetch(32'h14, 1'b0);
      cycle(1'b1, 32'h18, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      idle(2, 1'b1);
      fetch(32'h8, 1'b1);
      idle(3, 1'b1);

      // Read-first on a same-cycle write and fetch of one word.
      cycle(1'b1, 32'h4, 1'b1, 1'b0, 1'b1, 32'h4, 32'hDEAD_BEEF);
      fetch(32'h4, 1'b1);
      idle(3, 1'b1);

      // Asynchronous reset between edges with two responses buffered.
      fetch(32'h0, 1'b0);
      fetch(32'h4, 1'b0);
      idle(3, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async");
      q.delete();
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      fetch(32'h0, 1'b1);
      fetch(32'h4, 1'b1);
      idle(3, 1'b1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 2) != 0,
               $urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0, rand_addr(), $urandom);
      end
      idle(LATENCY + RESP_DEPTH + 2, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Instruction-memory responder: the consumer end of the PC / PC-update path.
- Accepts fetch requests carrying the current PC on a valid/ready handshake.
- Reads a word-addressed instruction store and returns instruction, address and error flag after a fixed pipeline latency, through a credit-limited response FIFO.
- Supports a pipeline flush on branch, jump or jr redirect, and a program-load write port.

Parameters:
- DEPTH, 256, number of 32-bit instruction words in the store (power of 2).
- LATENCY, 2, request-accept to FIFO-write delay in cycles (legal 1..4).
- RESP_DEPTH, 4, response FIFO entries (power of 2, >= LATENCY).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_addr  in  32  byte address (PC) to fetch.
- req_ready  out  1  request accepted this cycle when req_valid and req_ready are both 1.
- flush  in  1  redirect: discard every in-flight and buffered response.
- resp_valid  out  1  response at FIFO head is valid.
- resp_ready  in  1  consumer takes the head response this cycle.
- resp_instr  out  32  fetched instruction word.
- resp_addr  out  32  req_addr of that response.
- resp_err  out  1  misaligned or out-of-range fetch.
- wr_en  in  1  program-load write strobe.
- wr_addr  in  32  byte address of the write (word index = wr_addr[31:2]).
- wr_data  in  32  instruction word to store.

Behaviour:
- Reset (async, rst=1): pipeline valid bits = 0; FIFO pointers and count = 0; outstanding counter = 0.
  - Outputs: req_ready=0 while rst asserted, resp_valid=0, resp_instr=0, resp_addr=0, resp_err=0.
  - Store contents are not reset. Reset mid-operation drops all traffic immediately.
- Credit rule:
  - outstanding = pipeline occupancy + FIFO count.
  - req_ready = !rst && !flush && (outstanding < RESP_DEPTH).
  - Because of this rule, a FIFO write never finds the FIFO full, so no overflow path exists.
- Accept: on a cycle with req_valid && req_ready, the request enters pipeline stage 0. After LATENCY posedges it is written to the FIFO, so the earliest resp_valid is LATENCY cycles after acceptance. Throughput is one per cycle when resp_ready is held high.
- Read: the word at index req_addr[31:2] is sampled at stage 0.
  - Error case: resp_err=1 and resp_instr=32'h00000000 (nop) if req_addr[1:0]!=0 or req_addr[31:2] >= DEPTH. resp_addr still carries the address.
- Write: when wr_en=1 and wr_addr[31:2] < DEPTH, the store is written at posedge. Out-of-range writes are ignored.
  - A fetch of the same index in the same cycle returns the old data (read-first).
  - wr_en has no effect on handshakes.
- Pop: the head is removed when resp_valid && resp_ready. resp_* outputs are driven from the FIFO head and stay stable while resp_valid=1 and resp_ready=0.
- Simultaneous write and pop on the FIFO: both occur and count is unchanged. An empty FIFO with a same-cycle write shows resp_valid the next cycle; there is no fall-through.
- Flush (synchronous):
  - At the posedge with flush=1, all pipeline valid bits clear, FIFO pointers and count clear, and outstanding becomes 0.
  - Any request presented that cycle is not accepted (req_ready=0). Any pop that cycle is void.
  - resp_valid=0 from the following cycle until a post-flush request completes.
- Pointer wrap: FIFO read/write pointers are log2(RESP_DEPTH) bits and wrap modulo RESP_DEPTH. Count is held separately (0..RESP_DEPTH).
- Outstanding counter:
  - +1 on accept, −1 on pop, unchanged if both happen, cleared on flush.
  - Never exceeds RESP_DEPTH.

Decomposition:
- Shared package fetch_pkg:
  - NOP_INSTR = 32'h00000000;
  - WORD_BYTES = 4;
  - response record layout {err, addr[31:0], instr[31:0]} = 65 bits.
- One natural sub-module: resp_fifo (parameterised width/depth, synchronous clear input driven by flush, async reset).
- Pipeline and store stay in the top.

Test Plan:
- Reset, then load words 0x20080005 @0x0 and 0x2009000A @0x4; request 0x0 and 0x4 on consecutive cycles with resp_ready=1 -> resp_valid at accept+2; instr 0x20080005 then 0x2009000A; err=0; addresses echo.
- req_addr=0x6 -> resp_err=1, resp_instr=0x00000000, resp_addr=0x6. req_addr=0x400 (index 256, DEPTH=256) -> resp_err=1.
- Hold resp_ready=0, stream requests -> exactly 4 accepted; req_ready=0 thereafter. Release resp_ready -> 4 responses in order, then req_ready returns to 1.
- Issue 3 requests, assert flush the cycle after the third together with req_valid -> that request is not accepted; resp_valid stays 0; the next request to 0x8 is the first response seen.
- Same-cycle wr_en to 0x4 (data 0xDEADBEEF) and fetch of 0x4 -> returns the old value; the next fetch of 0x4 returns 0xDEADBEEF.
- Assert rst asynchronously (between edges) with 2 responses buffered -> resp_valid=0 and resp_* = 0 immediately; after release req_ready=1 and the store contents are intact.
